hangy_input_conditioner: RTL and testbench

Front-end stage that sits directly upstream of the hangy game core and drives its 6-bit chip_input.
- Synchronizes and debounces the raw pad inputs: the next button and the 5-bit letter code.
- Converts each button press into a single-cycle next pulse, with the letter held stable alongside it.
- During guessing, filters out invalid letter codes and letters already guessed, so the core only ever sees fresh, legal guesses.

---
 rtl/hangy_input_conditioner.sv | 139 +++++++++++++
 tb/tb_hangy_input_conditioner.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/hangy_input_conditioner.sv
// rtl/hangy_input_conditioner.sv - pad synchronizer, button debounce and guess filter feeding the hangy core
module hangy_input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ALPHABET        = 26
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          raw_in,
    input  logic                guess_mode,
    input  logic                clear_history,
    output logic                next_pulse,
    output logic [4:0]          char_out,
    output logic                invalid_char,
    output logic                dup_guess,
    output logic [ALPHABET-1:0] history
);

    localparam int                CNT_W     = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [5:0]        ALPHA_LIM = 6'(ALPHABET);

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_t;

    logic [5:0]          sync_q [SYNC_STAGES];
    logic                next_sync;
    logic [4:0]          char_sync;
    logic [CNT_W-1:0]    db_count;
    logic                stable_next;

    state_t              state_q;
    state_t              state_d;
    logic                pulse_d;
    logic                invalid_d;
    logic                dup_d;
    logic [4:0]          char_d;
    logic [ALPHABET-1:0] history_d;
    logic [ALPHABET-1:0] letter_bit;

    assign next_sync = sync_q[SYNC_STAGES-1][5];
    assign char_sync = sync_q[SYNC_STAGES-1][4:0];

    // Multi-flop synchronizer chain for every pad bit
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= raw_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Button debounce: a changed level must persist DEBOUNCE_CYCLES cycles before it is accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            db_count    <= '0;
            stable_next <= 1'b0;
        end else if (next_sync == stable_next) begin
            db_count <= '0;
        end else if (db_count == CNT_MAX) begin
            stable_next <= next_sync;
            db_count    <= '0;
        end else begin
            db_count <= db_count + 1'b1;
        end
    end

    // Press evaluation and next-state; a stable high seen in IDLE can only be a fresh rising edge,
    // because HELD is left only once the debounced level has returned to 0
    always_comb begin
        state_d    = state_q;
        pulse_d    = 1'b0;
        invalid_d  = 1'b0;
        dup_d      = 1'b0;
        char_d     = char_out;
        history_d  = history;
        letter_bit = ALPHABET'(1) << char_sync;

        case (state_q)
            IDLE: begin
                if (stable_next) begin
                    state_d = HELD;
                    if (!guess_mode) begin
                        pulse_d = 1'b1;
                        char_d  = char_sync;
                    end else if ({1'b0, char_sync} >= ALPHA_LIM) begin
                        invalid_d = 1'b1;
                    end else if ((history & letter_bit) != '0) begin
                        dup_d = 1'b1;
                    end else begin
                        pulse_d   = 1'b1;
                        char_d    = char_sync;
                        history_d = history | letter_bit;
                    end
                end
            end
            HELD: begin
                if (!stable_next) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A clear arriving with an accepted guess still empties the history
        if (clear_history) begin
            history_d = '0;
        end
    end

    // State register and registered one-cycle outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            next_pulse   <= 1'b0;
            invalid_char <= 1'b0;
            dup_guess    <= 1'b0;
            char_out     <= '0;
            history      <= '0;
        end else begin
            state_q      <= state_d;
            next_pulse   <= pulse_d;
            invalid_char <= invalid_d;
            dup_guess    <= dup_d;
            char_out     <= char_d;
            history      <= history_d;
        end
    end

endmodule

// File: tb/tb_hangy_input_conditioner.sv
// tb/tb_hangy_input_conditioner.sv - directed self-checking bench for hangy_input_conditioner
module tb_hangy_input_conditioner;

    logic        clk;
    logic        reset;
    logic [5:0]  raw_in;
    logic        guess_mode;
    logic        clear_history;
    logic        next_pulse;
    logic [4:0]  char_out;
    logic        invalid_char;
    logic        dup_guess;
    logic [25:0] history;

    int compared;
    int mismatched;
    int pulse_cnt, pulse_at, inv_cnt, inv_at, dup_cnt, dup_at;
    int rel_events;
    int bounce_pulses;

    hangy_input_conditioner #(
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(16),
        .ALPHABET(26)
    ) dut (
        .clk(clk),
        .reset(reset),
        .raw_in(raw_in),
        .guess_mode(guess_mode),
        .clear_history(clear_history),
        .next_pulse(next_pulse),
        .char_out(char_out),
        .invalid_char(invalid_char),
        .dup_guess(dup_guess),
        .history(history)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        pulse_cnt = 0; pulse_at = -1;
        inv_cnt   = 0; inv_at   = -1;
        dup_cnt   = 0; dup_at   = -1;
    endtask

    task automatic sample_events(input int i);
        if (next_pulse === 1'b1) begin
            pulse_cnt++;
            if (pulse_at < 0) pulse_at = i;
        end
        if (invalid_char === 1'b1) begin
            inv_cnt++;
            if (inv_at < 0) inv_at = i;
        end
        if (dup_guess === 1'b1) begin
            dup_cnt++;
            if (dup_at < 0) dup_at = i;
        end
    endtask

    // Hold the button with a letter for 'hold' edges; clear_history is sampled on edge clr_at
    task automatic press(input logic [4:0] code, input logic gm, input int hold, input int clr_at);
        clear_counts();
        guess_mode = gm;
        raw_in     = {1'b1, code};
        for (int i = 1; i <= hold; i++) begin
            clear_history = (i == clr_at);
            tick();
            sample_events(i);
        end
        clear_history = 1'b0;
    endtask

    task automatic release_button();
        raw_in[5] = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (next_pulse === 1'b1 || invalid_char === 1'b1 || dup_guess === 1'b1) rel_events++;
        end
    endtask

    initial begin
        compared      = 0;
        mismatched    = 0;
        rel_events    = 0;
        bounce_pulses = 0;
        reset         = 1'b1;
        raw_in        = '0;
        guess_mode    = 1'b0;
        clear_history = 1'b0;
        clear_counts();

        tick(); tick(); tick();
        check("reset_next_pulse", 32'(next_pulse), 32'd0);
        check("reset_char_out",   32'(char_out),   32'd0);
        check("reset_invalid",    32'(invalid_char), 32'd0);
        check("reset_dup",        32'(dup_guess),  32'd0);
        check("reset_history",    32'(history),    32'd0);
        reset = 1'b0;
        tick();

        // Bounce: 10 high, 5 low, 10 high never reaches the 16-cycle threshold
        guess_mode = 1'b1;
        raw_in = 6'b100000;
        for (int i = 0; i < 10; i++) begin tick(); if (next_pulse === 1'b1) bounce_pulses++; end
        raw_in = 6'b000000;
        for (int i = 0; i < 5; i++)  begin tick(); if (next_pulse === 1'b1) bounce_pulses++; end
        raw_in = 6'b100000;
        for (int i = 0; i < 10; i++) begin tick(); if (next_pulse === 1'b1) bounce_pulses++; end
        raw_in = 6'b000000;
        for (int i = 0; i < 25; i++) begin tick(); if (next_pulse === 1'b1) bounce_pulses++; end
        check("bounce_no_pulse", 32'(bounce_pulses), 32'd0);
        check("bounce_history",  32'(history),       32'd0);

        // Clean press of letter 2
        press(5'd2, 1'b1, 40, 0);
        check("clean_pulse_count", 32'(pulse_cnt), 32'd1);
        check("clean_pulse_edge",  32'(pulse_at),  32'd19);
        check("clean_char_out",    32'(char_out),  32'd2);
        check("clean_history",     32'(history),   32'h0000004);
        check("clean_no_reject",   32'(inv_cnt + dup_cnt), 32'd0);
        release_button();

        // Duplicate of letter 2
        press(5'd2, 1'b1, 40, 0);
        check("dup_count",    32'(dup_cnt),   32'd1);
        check("dup_edge",     32'(dup_at),    32'd19);
        check("dup_no_pulse", 32'(pulse_cnt), 32'd0);
        check("dup_history",  32'(history),   32'h0000004);
        check("dup_char_out", 32'(char_out),  32'd2);
        release_button();

        // Fresh letter 4
        press(5'd4, 1'b1, 40, 0);
        check("l4_pulse_count", 32'(pulse_cnt), 32'd1);
        check("l4_char_out",    32'(char_out),  32'd4);
        check("l4_history",     32'(history),   32'h0000014);
        release_button();

        // Invalid code 27 while guessing
        press(5'd27, 1'b1, 40, 0);
        check("inv_count",    32'(inv_cnt),   32'd1);
        check("inv_edge",     32'(inv_at),    32'd19);
        check("inv_no_pulse", 32'(pulse_cnt), 32'd0);
        check("inv_char_out", 32'(char_out),  32'd4);
        check("inv_history",  32'(history),   32'h0000014);
        release_button();

        // Code 27 outside guessing passes unfiltered
        press(5'd27, 1'b0, 40, 0);
        check("nogm_pulse_count", 32'(pulse_cnt), 32'd1);
        check("nogm_no_reject",   32'(inv_cnt + dup_cnt), 32'd0);
        check("nogm_char_out",    32'(char_out),  32'd27);
        check("nogm_history",     32'(history),   32'h0000014);
        release_button();

        // Clear colliding with accepted guess of 7
        press(5'd7, 1'b1, 40, 19);
        check("clr_pulse_count", 32'(pulse_cnt), 32'd1);
        check("clr_pulse_edge",  32'(pulse_at),  32'd19);
        check("clr_char_out",    32'(char_out),  32'd7);
        check("clr_history",     32'(history),   32'd0);
        release_button();
        check("release_silent",  32'(rel_events), 32'd0);

        // Reset at debounce count 10 with the button held
        guess_mode = 1'b1;
        raw_in     = {1'b1, 5'd3};
        for (int i = 0; i < 12; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_char_out", 32'(char_out),   32'd0);
        check("rst_mid_pulse",    32'(next_pulse), 32'd0);
        check("rst_mid_history",  32'(history),    32'd0);
        clear_counts();
        for (int i = 1; i <= 40; i++) begin
            tick();
            sample_events(i);
        end
        check("rst_mid_pulse_edge",  32'(pulse_at),  32'd19);
        check("rst_mid_pulse_count", 32'(pulse_cnt), 32'd1);
        check("rst_mid_char_after",  32'(char_out),  32'd3);
        check("rst_mid_hist_after",  32'(history),   32'h0000008);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
